// File: rtl/raster_pkg.sv
// Shared raster types and screen limits for the triangle filler stages.
// Imported by the triangle setup, the edge walkers and the span filler.
package raster_pkg;

    localparam int COORD_W  = 9;
    localparam int COLOUR_W = 16;
    localparam int MAX_X    = 479;
    localparam int MAX_Y    = 271;

    typedef logic [COORD_W-1:0]  coord_t;
    typedef logic [COLOUR_W-1:0] colour_t;

    typedef enum logic {
        S_WAIT = 1'b0,
        S_EMIT = 1'b1
    } span_state_e;

endpackage

// File: rtl/span_filler.sv
// Pairs same-row points from the two edge walkers into a clipped span and emits it one pixel per cycle.
// First pixel 1 cycle after capture; pixels held while px_ready=0; walkers acked at capture.
module span_filler
    import raster_pkg::*;
#(
    parameter int COORD_W  = raster_pkg::COORD_W,
    parameter int COLOUR_W = raster_pkg::COLOUR_W,
    parameter int MAX_X    = raster_pkg::MAX_X,
    parameter int MAX_Y    = raster_pkg::MAX_Y
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [COORD_W-1:0]  a_x,
    input  logic [COORD_W-1:0]  a_y,
    input  logic                a_valid,
    output logic                a_ack,
    input  logic [COORD_W-1:0]  b_x,
    input  logic [COORD_W-1:0]  b_y,
    input  logic                b_valid,
    output logic                b_ack,
    output logic [COORD_W-1:0]  px_x,
    output logic [COORD_W-1:0]  px_y,
    output logic [COLOUR_W-1:0] px_colour,
    output logic                px_valid,
    input  logic                px_ready,
    output logic                busy,
    output logic [15:0]         span_count
);

    localparam logic [COORD_W-1:0] MAX_X_C = COORD_W'(MAX_X);
    localparam logic [COORD_W-1:0] MAX_Y_C = COORD_W'(MAX_Y);

    span_state_e         state;
    logic [COORD_W-1:0]  xl;
    logic [COORD_W-1:0]  xr;
    logic [COORD_W-1:0]  cur;
    logic [COORD_W-1:0]  y;
    logic [COLOUR_W-1:0] col;

    logic               a_ok;
    logic               b_ok;
    logic [COORD_W-1:0] lo;
    logic [COORD_W-1:0] hi;
    logic               clip;

    // A walker still shows the point it is being acked for, so mask it that cycle.
    assign a_ok = a_valid && !a_ack;
    assign b_ok = b_valid && !b_ack;
    assign lo   = (a_x < b_x) ? a_x : b_x;
    assign hi   = (a_x < b_x) ? b_x : a_x;
    assign clip = (a_y > MAX_Y_C) || (lo > MAX_X_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_WAIT;
            xl         <= '0;
            xr         <= '0;
            cur        <= '0;
            y          <= '0;
            col        <= '0;
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            px_valid   <= 1'b0;
            span_count <= '0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (a_ok && b_ok) begin
                        if (a_y == b_y) begin
                            a_ack <= 1'b1;
                            b_ack <= 1'b1;
                            xl    <= lo;
                            xr    <= (hi > MAX_X_C) ? MAX_X_C : hi;
                            y     <= a_y;
                            col   <= colour;
                            if (!clip) begin
                                cur      <= lo;
                                px_valid <= 1'b1;
                                state    <= S_EMIT;
                            end
                        end else if (a_y < b_y) begin
                            a_ack <= 1'b1;
                        end else begin
                            b_ack <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (px_ready) begin
                        if (cur == xr) begin
                            px_valid   <= 1'b0;
                            span_count <= span_count + 16'd1;
                            state      <= S_WAIT;
                        end else begin
                            cur <= cur + 1'b1;
                        end
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    assign px_x      = cur;
    assign px_y      = y;
    assign px_colour = col;
    assign busy      = (state == S_EMIT) || a_ack || b_ack;

endmodule

// File: tb/tb_span_filler.sv
// Drives two modelled edge walkers into span_filler and checks every pixel, ack and count
// against a row-pairing reference computed directly from the point lists.
module tb_span_filler;
    import raster_pkg::*;

    localparam int CW = 9;
    localparam int KW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [KW-1:0] colour;
    logic [CW-1:0] a_x, a_y, b_x, b_y;
    logic          a_valid, b_valid, a_ack, b_ack;
    logic [CW-1:0] px_x, px_y;
    logic [KW-1:0] px_colour;
    logic          px_valid, px_ready, busy;
    logic [15:0]   span_count;

    always #5 clk = ~clk;

    span_filler dut (
        .clk(clk), .reset(reset), .colour(colour),
        .a_x(a_x), .a_y(a_y), .a_valid(a_valid), .a_ack(a_ack),
        .b_x(b_x), .b_y(b_y), .b_valid(b_valid), .b_ack(b_ack),
        .px_x(px_x), .px_y(px_y), .px_colour(px_colour), .px_valid(px_valid),
        .px_ready(px_ready), .busy(busy), .span_count(span_count)
    );

    typedef struct { int x; int y; } pt_t;
    typedef struct { int x; int y; logic [KW-1:0] c; bit last; } px_t;

    pt_t qa[$], qb[$];
    px_t exp_px[$];
    bit  exp_cap[$];
    int  total = 0, bad = 0;
    int  got_a, got_b, exp_a, exp_b, exp_spans;
    bit  mon_en = 0, gaps_en = 0, pop_a = 0, pop_b = 0;
    int  gap_a = 0, gap_b = 0, rdy_mode = 0;
    logic [KW-1:0] cur_colour = '0;

    bit            prev_vld, prev_rdy, prev_hs, prev_last, prev_a, prev_b;
    logic [CW-1:0] prev_x, prev_y;
    logic [KW-1:0] prev_c;

    assign colour = cur_colour;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Walker A: holds its point through the ack cycle, then advances, optionally after a gap.
    always @(posedge clk) begin
        #1;
        if (pop_a) begin
            pop_a = 0;
            if (qa.size() > 0) qa.delete(0);
            gap_a = gaps_en ? int'($urandom_range(0, 2)) : 0;
        end
        if (gap_a > 0) begin
            a_valid = 1'b0;
            gap_a--;
        end else if (qa.size() > 0) begin
            a_valid = 1'b1;
            a_x = CW'(qa[0].x);
            a_y = CW'(qa[0].y);
        end else begin
            a_valid = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (pop_b) begin
            pop_b = 0;
            if (qb.size() > 0) qb.delete(0);
            gap_b = gaps_en ? int'($urandom_range(0, 2)) : 0;
        end
        if (gap_b > 0) begin
            b_valid = 1'b0;
            gap_b--;
        end else if (qb.size() > 0) begin
            b_valid = 1'b1;
            b_x = CW'(qb[0].x);
            b_y = CW'(qb[0].y);
        end else begin
            b_valid = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       px_ready = 1'b1;
            1:       px_ready = ~px_ready;
            default: px_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (a_ack) pop_a = 1;
        if (b_ack) pop_b = 1;
        if (mon_en) begin
            if (a_ack) begin got_a++; check_eq("a_ack_run", prev_a, 0); end
            if (b_ack) begin got_b++; check_eq("b_ack_run", prev_b, 0); end
            if (a_ack && b_ack) begin
                check_eq("cap_pending", exp_cap.size() > 0, 1);
                if (exp_cap.size() > 0) check_eq("cap_emit", px_valid, exp_cap.pop_front());
            end
            if (prev_vld && !prev_rdy)
                check_eq("hold", {px_valid, px_x, px_y, px_colour}, {1'b1, prev_x, prev_y, prev_c});
            if (prev_hs && !prev_last) check_eq("thru", px_valid, 1);
            if (prev_hs && prev_last)  check_eq("gap", px_valid, 0);
            if (px_valid) check_eq("busy", busy, 1);
            prev_hs = 0;
            if (px_valid && px_ready) begin
                check_eq("px_pending", exp_px.size() > 0, 1);
                if (exp_px.size() > 0) begin
                    px_t e;
                    e = exp_px.pop_front();
                    check_eq("px", {px_x, px_y, px_colour}, {CW'(e.x), CW'(e.y), e.c});
                    prev_hs   = 1;
                    prev_last = e.last;
                end
            end
            prev_vld = px_valid; prev_rdy = px_ready;
            prev_x = px_x; prev_y = px_y; prev_c = px_colour;
            prev_a = a_ack; prev_b = b_ack;
        end
    end

    // Reference: walk both point lists row by row, the way the filler is meant to pair them.
    task automatic build_model();
        pt_t ma[$], mb[$];
        ma = qa; mb = qb;
        exp_a = 0; exp_b = 0; exp_spans = 0;
        while (ma.size() > 0 && mb.size() > 0) begin
            if (ma[0].y == mb[0].y) begin
                int lo, hi, yy;
                lo = (ma[0].x < mb[0].x) ? ma[0].x : mb[0].x;
                hi = (ma[0].x < mb[0].x) ? mb[0].x : ma[0].x;
                yy = ma[0].y;
                exp_a++; exp_b++;
                if (yy > MAX_Y || lo > MAX_X) begin
                    exp_cap.push_back(0);
                end else begin
                    if (hi > MAX_X) hi = MAX_X;
                    exp_cap.push_back(1);
                    exp_spans++;
                    for (int x = lo; x <= hi; x++) exp_px.push_back('{x, yy, cur_colour, x == hi});
                end
                ma.delete(0); mb.delete(0);
            end else if (ma[0].y < mb[0].y) begin
                exp_a++; ma.delete(0);
            end else begin
                exp_b++; mb.delete(0);
            end
        end
    endtask

    task automatic prep();
        @(negedge clk); #2;
        mon_en = 0; reset = 1'b1;
        qa.delete(); qb.delete(); exp_px.delete(); exp_cap.delete();
        pop_a = 0; pop_b = 0; gap_a = 0; gap_b = 0;
        got_a = 0; got_b = 0;
        prev_vld = 0; prev_rdy = 0; prev_hs = 0; prev_last = 0; prev_a = 0; prev_b = 0;
        @(negedge clk);
    endtask

    task automatic run(input int mode, input bit gaps, input logic [KW-1:0] c);
        int n, pts;
        rdy_mode = mode; gaps_en = gaps; cur_colour = c;
        pts = qa.size() + qb.size();
        build_model();
        #2;
        reset = 1'b0; mon_en = 1;
        n = 0;
        while ((exp_px.size() > 0 || exp_cap.size() > 0) && n < 20000) begin
            @(negedge clk); n++;
        end
        repeat (8 * pts + 10) @(negedge clk);
        check_eq("drain", exp_px.size(), 0);
        check_eq("cap_left", exp_cap.size(), 0);
        check_eq("acks_a", got_a, exp_a);
        check_eq("acks_b", got_b, exp_b);
        check_eq("span_count", span_count, exp_spans);
    endtask

    task automatic reset_mid_span();
        bit found;
        prep();
        qa.push_back('{1, 2});  qb.push_back('{1, 2});
        qa.push_back('{10, 3}); qb.push_back('{20, 3});
        rdy_mode = 0; gaps_en = 0; cur_colour = 16'h07E0;
        #2 reset = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (px_valid && px_x == 12) found = 1;
        end
        check_eq("rst_reach", found, 1);
        check_eq("rst_pre_cnt", span_count, 1);
        #2 reset = 1'b1;
        @(negedge clk);
        check_eq("rst_px_valid", px_valid, 0);
        check_eq("rst_acks", {a_ack, b_ack}, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_count", span_count, 0);
    endtask

    initial begin
        reset = 1'b1; px_ready = 1'b1;
        a_valid = 0; b_valid = 0; a_x = '0; a_y = '0; b_x = '0; b_y = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_state", {px_valid, a_ack, b_ack, busy, span_count, px_x, px_y, px_colour}, 0);

        prep(); qa.push_back('{10, 5}); qb.push_back('{13, 5});
        run(0, 0, 16'hF800);

        prep(); qa.push_back('{20, 7}); qb.push_back('{17, 7});
        run(1, 0, 16'h1234);

        prep();
        qa.push_back('{470, 9}); qa.push_back('{485, 10});
        qb.push_back('{500, 9}); qb.push_back('{490, 10});
        run(0, 0, 16'hABCD);

        prep();
        qa.push_back('{3, 4}); qa.push_back('{4, 5});
        qb.push_back('{6, 5});
        run(2, 0, 16'h5555);

        prep();
        for (int r = 1; r <= 4; r++) begin
            qa.push_back('{30 + r, r}); qb.push_back('{30 - r, r});
        end
        run(0, 0, 16'h00FF);

        reset_mid_span();
        prep(); qa.push_back('{100, 50}); qb.push_back('{96, 50});
        run(0, 0, 16'hBEEF);

        for (int p = 0; p < 6; p++) begin
            int cx, ya, yb, start;
            prep();
            cx = $urandom_range(0, 511);
            start = $urandom_range(0, 280);
            ya = start; yb = start;
            for (int i = 0; i < int'($urandom_range(3, 8)); i++) begin
                int xa, xb;
                ya += (i == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
                yb += (i == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
                xa = cx + int'($urandom_range(0, 40)) - 20;
                xb = cx + int'($urandom_range(0, 40)) - 20;
                xa = (xa < 0) ? 0 : (xa > 511 ? 511 : xa);
                xb = (xb < 0) ? 0 : (xb > 511 ? 511 : xb);
                qa.push_back('{xa, ya % 512});
                qb.push_back('{xb, yb % 512});
            end
            run(p % 3, p[0], 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
